// File: rtl/freq_gate_ctrl_pkg.sv
// Shared definitions for the frequency-meter gate sequencer.
// State encoding and default gate window lengths.
package freq_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int GATE_CYCLES_SIM   = 1000;
  localparam int GATE_CYCLES_BOARD = 50_000_000;

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Handshake bundle between the board pins, the gate sequencer and the BCD digit chain.
// master drives the measurement inputs; slave is the sequencer.
interface freq_gate_ctrl_if;
  logic run;
  logic sig_in;
  logic chain_max;
  logic cnt_clr;
  logic cnt_enb;
  logic cnt_ld;
  logic busy;
  logic overflow;

  modport master (
    output run, sig_in, chain_max,
    input  cnt_clr, cnt_enb, cnt_ld, busy, overflow
  );

  modport slave (
    input  run, sig_in, chain_max,
    output cnt_clr, cnt_enb, cnt_ld, busy, overflow
  );
endinterface

// File: rtl/freq_gate_ctrl_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous level input.
// Also usable for debounced push-buttons.
module freq_gate_ctrl_sync_edge (
  input  logic ck,
  input  logic rst_s,
  input  logic d,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge ck) begin
    if (!rst_s) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Built only from flop outputs, so the pulse is glitch-free.
  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate sequencer for a cascaded BCD frequency meter: clear, count for a fixed window,
// latch the displays and report overflow.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for run=1, all strobes low
//   ST_CLEAR | one cycle, clears digit counters and gate_ovf
//   ST_GATE  | GATE_CYCLES cycles, sig_in rising edges counted
//   ST_LATCH | one cycle, loads display registers, latches overflow
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_SIM,
  parameter int CNT_W       = 10
) (
  input logic              ck,
  input logic              rst_s,
  freq_gate_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] gate_cnt_q;
  logic             gate_ovf_q;
  logic             overflow_q;
  logic             rise;
  logic             gate_done;
  logic             cnt_clr, cnt_enb, cnt_ld, busy;

  freq_gate_ctrl_sync_edge u_sync_edge (
    .ck    (ck),
    .rst_s (rst_s),
    .d     (bus.sig_in),
    .rise  (rise)
  );

  assign gate_done = (gate_cnt_q == GATE_LAST);

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_enb = 1'b0;
    cnt_ld  = 1'b0;
    busy    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.run) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_clr = 1'b1;
        state_d = ST_GATE;
      end
      ST_GATE: begin
        cnt_enb = rise;
        if (gate_done) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        cnt_ld  = 1'b1;
        state_d = bus.run ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst_s) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      gate_ovf_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_CLEAR: begin
          gate_cnt_q <= '0;
          gate_ovf_q <= 1'b0;
        end
        ST_GATE: begin
          if (!gate_done) gate_cnt_q <= gate_cnt_q + 1'b1;
          // Chain at all-nines plus one more count wraps to zero.
          if (cnt_enb && bus.chain_max) gate_ovf_q <= 1'b1;
        end
        ST_LATCH: overflow_q <= gate_ovf_q;
        default: ;
      endcase
    end
  end

  assign bus.cnt_clr  = cnt_clr;
  assign bus.cnt_enb  = cnt_enb;
  assign bus.cnt_ld   = cnt_ld;
  assign bus.busy     = busy;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl with a sample-history reference model.
module tb_freq_gate_ctrl;

  localparam int G      = 20;
  localparam int HIST_N = 8192;

  logic ck;
  logic rst_s;

  freq_gate_ctrl_if bus ();

  freq_gate_ctrl #(.GATE_CYCLES(G), .CNT_W(5)) dut (
    .ck    (ck),
    .rst_s (rst_s),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    int ld_cyc;
    int n_enb;
  } rec_t;

  rec_t sb[$];

  // sampled history, indexed by edge number
  bit eff[0:HIST_N-1];
  bit cm[0:HIST_N-1];

  int cyc      = -1;
  int meas     = -1;
  bit pend_ovf = 1'b0;
  bit exp_ovf  = 1'b0;
  bit exp_busy = 1'b0;
  bit exp_clr  = 1'b0;
  bit exp_ld   = 1'b0;
  bit started  = 1'b0;
  bit done     = 1'b0;
  int sig_mode = 0;

  int total = 0;
  int bad   = 0;
  int enb_cnt = 0;

  // Reference: a measurement whose clear cycle is c has gate cycles c+1..c+G and
  // latch cycle c+G+1. Input seen high at edge m-1 and low at edge m-2 yields one
  // enable in cycle m; a reset edge counts as a low sample.
  always @(posedge ck) begin
    cyc = cyc + 1;
    eff[cyc] = rst_s ? bus.sig_in : 1'b0;
    cm[cyc]  = bus.chain_max;
    if (!rst_s) begin
      meas    = -1;
      exp_ovf = 1'b0;
    end else if (meas < 0) begin
      if (bus.run) meas = cyc;
    end else if (cyc == meas + G + 2) begin
      exp_ovf = pend_ovf;
      meas    = bus.run ? cyc : -1;
    end
    exp_busy = (meas >= 0);
    exp_clr  = (meas >= 0) && (cyc == meas);
    exp_ld   = (meas >= 0) && (cyc == meas + G + 1);
    if (exp_ld) begin
      rec_t r;
      bit   o;
      r.ld_cyc = cyc;
      r.n_enb  = 0;
      o        = 1'b0;
      for (int m = meas + 1; m <= meas + G; m++) begin
        if (eff[m-1] && !eff[m-2]) begin
          r.n_enb++;
          if (cm[m+1]) o = 1'b1;
        end
      end
      sb.push_back(r);
      pend_ovf = o;
    end
    started = 1'b1;
  end

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  always @(negedge ck) begin
    if (started) begin
      check("busy",     int'(bus.busy),     int'(exp_busy));
      check("overflow", int'(bus.overflow), int'(exp_ovf));
      check("cnt_clr",  int'(bus.cnt_clr),  int'(exp_clr));
      check("cnt_ld",   int'(bus.cnt_ld),   int'(exp_ld));
      check("exclusive", int'((32'(bus.cnt_clr) + 32'(bus.cnt_enb) + 32'(bus.cnt_ld)) <= 1), 1);
      if (!exp_busy) check("enb_idle", int'(bus.cnt_enb), 0);
      if (bus.cnt_clr === 1'b1) enb_cnt = 0;
      if (bus.cnt_enb === 1'b1) enb_cnt++;
      if (bus.cnt_ld === 1'b1) begin
        if (sb.size() == 0) begin
          check("ld_unexpected", 1, 0);
        end else begin
          rec_t r;
          r = sb.pop_front();
          check("ld_cycle", cyc, r.ld_cyc);
          check("enb_count", enb_cnt, r.n_enb);
        end
      end
    end
    if (done) begin
      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // sig_in: each level held 2..5 cycles (mode 0), fixed 2/2 (mode 2), or held high (mode 1)
  initial begin
    int hold;
    bus.sig_in = 1'b0;
    hold = 2;
    forever begin
      @(negedge ck);
      if (sig_mode == 1) begin
        bus.sig_in = 1'b1;
        hold = 2;
      end else begin
        hold--;
        if (hold <= 0) begin
          bus.sig_in = ~bus.sig_in;
          hold = (sig_mode == 2) ? 2 : int'($urandom_range(2, 5));
        end
      end
    end
  end

  task automatic wait_clear();
    for (int i = 0; i < 200 && !exp_clr; i++) @(negedge ck);
  endtask

  initial begin
    rst_s         = 1'b0;
    bus.run       = 1'b1;
    bus.chain_max = 1'b0;
    repeat (3) @(negedge ck);
    rst_s = 1'b1;

    sig_mode = 2;
    repeat (2 * (G + 2)) @(negedge ck);

    sig_mode = 1;
    wait_clear();
    repeat (G + 2) @(negedge ck);

    sig_mode = 2;
    bus.chain_max = 1'b1;
    wait_clear();
    repeat (G + 2) @(negedge ck);
    bus.chain_max = 1'b0;
    repeat (G + 2) @(negedge ck);

    wait_clear();
    repeat (11) @(negedge ck);
    bus.run = 1'b0;
    repeat (G + 5) @(negedge ck);

    bus.run       = 1'b1;
    bus.chain_max = 1'b1;
    wait_clear();
    repeat (11) @(negedge ck);
    rst_s = 1'b0;
    @(negedge ck);
    rst_s = 1'b1;
    bus.chain_max = 1'b0;
    repeat (G + 5) @(negedge ck);

    sig_mode = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge ck);
      if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
      bus.chain_max = ($urandom_range(0, 7) == 0);
      rst_s = ($urandom_range(0, 299) != 0);
    end

    rst_s   = 1'b1;
    bus.run = 1'b0;
    repeat (G + 6) @(negedge ck);
    done = 1'b1;
  end

endmodule
